// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  function automatic int unsigned groups_per_stage(int unsigned width, int unsigned group,
                                                   int unsigned stages);
    return (width / group) / stages;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block: every internal carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;
  logic [GROUP:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin
  always_comb begin
    logic v_t;
    w_c    = '0;
    v_t    = 1'b0;
    w_c[0] = cin;
    for (int i = 1; i <= int'(GROUP); i++) begin
      v_t = cin;
      for (int m = 0; m < i; m++) v_t = v_t & w_p[m];
      w_c[i] = v_t;
      for (int j = 0; j < i; j++) begin
        v_t = w_g[j];
        for (int m = j + 1; m < i; m++) v_t = v_t & w_p[m];
        w_c[i] = w_c[i] | v_t;
      end
    end
  end

  assign sum  = w_p ^ w_c[GROUP-1:0];
  assign cout = w_c[GROUP];
  assign cmsb = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/subtract unit: lookahead groups, rippling group carries, groups
// split evenly over STAGES elastic register stages with valid/ready flow control.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned GPS = groups_per_stage(WIDTH, GROUP, STAGES);
  localparam int unsigned SW  = GPS * GROUP;

  if ((WIDTH % GROUP) != 0 || ((WIDTH / GROUP) % STAGES) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH/GROUP groups must divide evenly into STAGES");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO   = k * SW;
    localparam int unsigned SRCW = WIDTH - LO;

    logic [SRCW-1:0]  w_a;
    logic [SRCW-1:0]  w_b;
    logic [SW-1:0]    w_bx;
    op_e              w_mode;
    logic             w_cin;
    logic             w_vin;
    logic             w_load;
    logic             w_cout;
    logic [LO+SW-1:0] w_sum;

    logic             r_vld;
    logic             r_c;
    logic [LO+SW-1:0] r_sum;

    if (k == 0) begin : g_src
      assign w_a    = in_a;
      assign w_b    = in_b;
      assign w_mode = op_e'(in_sub);
      // Subtraction is a + ~b + 1, so the carry-in is forced high
      assign w_cin  = (w_mode == OpSub) | in_cin;
      assign w_vin  = in_valid;
    end else begin : g_src
      assign w_a           = g_stage[k-1].g_rem.r_a;
      assign w_b           = g_stage[k-1].g_rem.r_b;
      assign w_mode        = g_stage[k-1].g_rem.r_mode;
      assign w_cin         = g_stage[k-1].r_c;
      assign w_vin         = g_stage[k-1].r_vld;
      assign w_sum[LO-1:0] = g_stage[k-1].r_sum;
    end

    assign w_bx = (w_mode == OpSub) ? ~w_b[SW-1:0] : w_b[SW-1:0];

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      logic w_gcin;
      logic w_gcout;
      logic w_gcm;

      if (j == 0) begin : g_ci
        assign w_gcin = w_cin;
      end else begin : g_ci
        assign w_gcin = g_grp[j-1].w_gcout;
      end

      cla_group #(
        .GROUP (GROUP)
      ) u_grp (
        .a    (w_a[j*GROUP +: GROUP]),
        .b    (w_bx[j*GROUP +: GROUP]),
        .cin  (w_gcin),
        .sum  (w_sum[LO + j*GROUP +: GROUP]),
        .cout (w_gcout),
        .cmsb (w_gcm)
      );
    end

    assign w_cout = g_grp[GPS-1].w_gcout;

    // A stage loads when empty or when its content leaves this cycle
    if (k == STAGES - 1) begin : g_ld
      assign w_load = !r_vld || out_ready;
    end else begin : g_ld
      assign w_load = !r_vld || g_stage[k+1].w_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_sum <= '0;
      end else if (w_load) begin
        r_vld <= w_vin;
        if (w_vin) begin
          r_c   <= w_cout;
          r_sum <= w_sum;
        end
      end
    end

    if (k < STAGES - 1) begin : g_rem
      localparam int unsigned REMW = SRCW - SW;
      logic [REMW-1:0] r_a;
      logic [REMW-1:0] r_b;
      op_e             r_mode;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a    <= '0;
          r_b    <= '0;
          r_mode <= OpAdd;
        end else if (w_load && w_vin) begin
          r_a    <= w_a[SRCW-1:SW];
          r_b    <= w_b[SRCW-1:SW];
          r_mode <= w_mode;
        end
      end
    end else begin : g_out
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_load && w_vin) begin
          r_ovf <= w_cout ^ g_grp[GPS-1].w_gcm;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].w_load;
  assign out_valid = g_stage[STAGES-1].r_vld;
  assign out_sum   = g_stage[STAGES-1].r_sum;
  assign out_cout  = g_stage[STAGES-1].r_c;
  assign out_ovf   = g_stage[STAGES-1].g_out.r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner cases, stall/reset scenarios and
// randomized traffic against an arithmetic reference model with an ordered queue.
module tb_cla_pipe_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  cla_pipe_adder #(
    .WIDTH  (16),
    .GROUP  (4),
    .STAGES (2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          stamp;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          last_lat = 0;
  logic [15:0] last_sum;
  logic        last_cout;
  logic        last_ovf;
  logic        hold_pend = 1'b0;
  logic [17:0] hold_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic sub);
    exp_t        r;
    int          sa;
    int          sb;
    int          s;
    logic [16:0] full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      full   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      r.sum  = full[15:0];
      r.cout = full[16];
      s      = sa + sb + int'(cin);
    end else begin
      r.sum  = a - b;
      r.cout = (a >= b);
      s      = sa - sb;
    end
    r.ovf   = (s > 32767) || (s < -32768);
    r.stamp = 0;
    return r;
  endfunction

  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic ordy, output logic fired);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = ordy;
    #1;
    if (hold_pend) begin
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_result", {14'd0, out_cout, out_ovf, out_sum}, {14'd0, hold_val});
    end
    hold_pend = out_valid && !out_ready;
    hold_val  = {out_cout, out_ovf, out_sum};
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sum", {16'd0, out_sum}, {16'd0, e.sum});
        check_eq("cout", {31'd0, out_cout}, {31'd0, e.cout});
        check_eq("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
        last_sum  = out_sum;
        last_cout = out_cout;
        last_ovf  = out_ovf;
        last_lat  = cyc - e.stamp;
        n_out++;
      end
    end
    fired = v && in_ready;
    if (fired) begin
      e       = model(a, b, cin, sub);
      e.stamp = cyc;
      exp_q.push_back(e);
    end
    cyc++;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub);
    logic f;
    int   n0;
    n0 = n_out;
    f  = 1'b0;
    for (int t = 0; t < 10 && !f; t++) step(1'b1, a, b, cin, sub, 1'b1, f);
    check_eq("op_accepted", {31'd0, f}, 32'd1);
    for (int t = 0; t < 10 && n_out == n0; t++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, f);
    check_eq("op_done", n_out - n0, 32'd1);
    check_eq("op_latency", last_lat, 32'd2);
  endtask

  task automatic check_res(input string tag, input logic [15:0] s, input logic c,
                           input logic o);
    check_eq(tag, {14'd0, last_cout, last_ovf, last_sum}, {14'd0, c, o, s});
  endtask

  logic [15:0] a_tab [6] = '{16'h0001, 16'h00FF, 16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF};
  logic [15:0] b_tab [6] = '{16'h0002, 16'h0001, 16'h4321, 16'hFFFF, 16'h8000, 16'h0001};

  initial begin
    logic f;
    int   idx;
    int   n0;
    int   acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check_eq("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check_eq("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Corner-case arithmetic; first op transfers on the first edge after release
    do_op(16'h0002, 16'h0006, 1'b0, 1'b0);
    check_res("add_small", 16'h0008, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    check_res("add_wrap", 16'h0000, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    check_res("add_cin_ovf", 16'h8000, 1'b0, 1'b1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    check_res("sub_borrow", 16'hFFFE, 1'b0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    check_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // Six back-to-back operands with the consumer stalled for five cycles
    idx = 0;
    n0  = n_out;
    for (int c = 0; c < 60 && (idx < 6 || n_out < n0 + 6); c++) begin
      step(idx < 6, a_tab[idx % 6], b_tab[idx % 6], idx[0], idx[1], c >= 5, f);
      if (f) idx++;
      if (c == 4) begin
        check_eq("stall_accepted", idx, 32'd2);
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    check_eq("stall_all_out", n_out - n0, 32'd6);

    // Reset with two results in flight
    step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, f);
    step(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, f);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_out_sum", {16'd0, out_sum}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, f);
    do_op(16'h00A0, 16'h000B, 1'b0, 1'b0);
    check_res("post_rst_op", 16'h00AB, 1'b0, 1'b0);

    // Randomized traffic with random consumer backpressure
    acc = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      step($urandom_range(0, 9) < 8, 16'($urandom()), 16'($urandom()), 1'($urandom()),
           1'($urandom()), $urandom_range(0, 9) < 7, f);
      if (f) acc++;
    end
    check_eq("rand_accepted", acc, 32'd10000);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
      step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, f);
    end
    check_eq("rand_drained", exp_q.size(), 32'd0);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, f);
    check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 Parameter GROUP, default 4: bits per carry-lookahead group.
REQ-003 Parameter STAGES, default 2: pipeline register stages, equal to latency in cycles.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operands present.
REQ-007 in_ready  output  1  adder accepts operands this cycle.
REQ-008 in_a  input  WIDTH  operand A.
REQ-009 in_b  input  WIDTH  operand B.
REQ-010 in_cin  input  1  carry-in (add mode only).
REQ-011 in_sub  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_sum  output  WIDTH  result.
REQ-015 out_cout  output  1  carry-out of MSB.
REQ-016 out_ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Add: out_sum/out_cout SHALL equal {cout,sum} = in_a + in_b + in_cin, modulo 2^(WIDTH+1).
REQ-018 Subtract: result SHALL equal in_a + ~in_b + 1; in_cin ignored; out_cout=1 means no borrow.
REQ-019 out_ovf SHALL be 1 iff the carry into the MSB differs from out_cout.
REQ-020 Within a group, carries SHALL come from generate/propagate lookahead; group carries SHALL ripple between groups.
REQ-021 The WIDTH/GROUP groups SHALL be split evenly across STAGES; stage k resolves its groups and registers partial sum, carry, remaining operand bits and op mode.
REQ-022 An input SHALL transfer when in_valid && in_ready; an output when out_valid && out_ready.
REQ-023 Each stage SHALL hold a valid bit; it SHALL load when empty or when its content moves downstream in the same cycle.
REQ-024 in_ready SHALL equal (stage 0 empty) or (stage 0 advancing this cycle); no combinational path from in_valid to in_ready.
REQ-025 Unstalled latency SHALL be exactly STAGES cycles from input transfer to out_valid; throughput one result per cycle.
REQ-026 With out_ready low, the pipeline SHALL fill with up to STAGES results, then deassert in_ready; no result dropped, duplicated or reordered.
REQ-027 Bubbles SHALL collapse: an empty stage accepts from upstream even when downstream is stalled.
REQ-028 out_sum/out_cout/out_ovf SHALL stay stable while out_valid && !out_ready.
REQ-029 Simultaneous input and output transfer on a full pipeline SHALL sustain full throughput.

Reset
REQ-030 While rst_n low, all stage valid bits, out_valid, out_sum, out_cout and out_ovf SHALL be 0; in_ready SHALL be 1 after release.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight results immediately, without waiting for a clock edge.
REQ-032 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package cla_pkg SHALL hold the op-mode encoding (ADD=0, SUB=1) and a function computing groups per stage.
REQ-034 Elaboration SHALL fail if WIDTH % GROUP != 0 or (WIDTH/GROUP) % STAGES != 0.
REQ-035 Sub-module cla_group SHALL implement one GROUP-bit lookahead block (inputs a, b, cin; outputs sum, cout, carry into MSB).

Verification (WIDTH=16, GROUP=4, STAGES=2)
REQ-036 Add 0x0002+0x0006, cin=0 -> after 2 cycles sum=0x0008, cout=0, ovf=0.
REQ-037 Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; add 0x7FFF+0x0000, cin=1 -> sum=0x8000, ovf=1.
REQ-038 Sub 0x0005-0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0; sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-039 Drive 6 back-to-back inputs with out_ready low for 5 cycles -> in_ready drops after 2 accepted; all 6 results emerge in order, held stable while stalled.
REQ-040 Assert rst_n low with 2 results in flight -> out_valid=0 at once, no stale result after release; next input returns after 2 cycles.
REQ-041 10k random operands, modes, cin and out_ready toggling vs. reference model -> zero mismatches, no loss.
